// File: rtl/snap_capture_ctrl.sv
// -----------------------------------------------------------------------------
// snap_capture_ctrl
//
// Write-side controller for the ADC snapshot buffer. Software arms a capture by
// raising arm. The block optionally waits for trig, then streams 2^ADDR_W
// consecutive valid ADC words into BRAM port A at addresses 0 upward. When the
// buffer is full it raises done and leaves the word count for CPU readback.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   arm          software level; a 0->1 transition starts a capture
//   use_trig     1 = wait for trig after arming, 0 = start immediately
//   trig         trigger, level-sampled only while armed
//   din          ADC word (DATA_W bits)
//   din_valid    din qualifier
//   bram_we      port-A write enable
//   bram_en_a    port-A enable, always equal to bram_we
//   bram_addr    port-A address (ADDR_W bits)
//   bram_wr_data port-A write data (DATA_W bits)
//   busy         high while armed or capturing
//   done         high once the buffer is full, until the next arm
//   count        words written in the current or last capture (ADDR_W+1 bits)
//
// All outputs are registered; a word accepted in cycle N is written in N+1.
// -----------------------------------------------------------------------------
module snap_capture_ctrl #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              use_trig,
    input  logic              trig,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              bram_we,
    output logic              bram_en_a,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Count value at which the next accepted word is the final one.
    localparam logic [ADDR_W:0]   LAST_COUNT = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0]   COUNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_reg, state_next;
    logic                arm_d_reg;
    logic [ADDR_W-1:0]   wr_ptr_reg;
    logic [ADDR_W:0]     count_reg;
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   data_reg;
    logic                busy_reg;
    logic                done_reg;

    logic                arm_rise;
    logic                accept;
    logic                clear;

    assign arm_rise = arm & ~arm_d_reg;

    // Next-state logic. accept marks a word taken this cycle; clear marks a
    // fresh arm that restarts count and address from zero.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        clear      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (arm_rise) begin
                    clear      = 1'b1;
                    state_next = S_ARMED;
                end
            end
            S_ARMED: begin
                // The word present in the trigger cycle is the first sample.
                if (~use_trig | trig) begin
                    state_next = S_CAPTURE;
                    accept     = din_valid;
                end
            end
            S_CAPTURE: begin
                accept = din_valid;
            end
            S_DONE: begin
                if (arm_rise) begin
                    clear      = 1'b1;
                    state_next = S_ARMED;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // The final word moves straight to DONE so that done rises together
        // with its write pulse.
        if (accept && (count_reg == LAST_COUNT)) begin
            state_next = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            arm_d_reg  <= 1'b0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            data_reg   <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            arm_d_reg <= arm;
            we_reg    <= accept;
            if (accept) begin
                addr_reg   <= wr_ptr_reg;
                data_reg   <= din;
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                count_reg  <= count_reg + COUNT_ONE;
            end else if (clear) begin
                wr_ptr_reg <= '0;
                count_reg  <= '0;
            end
            // Status flags follow the state being entered so they line up
            // with the registered write outputs.
            busy_reg <= (state_next == S_ARMED) || (state_next == S_CAPTURE);
            done_reg <= (state_next == S_DONE);
        end
    end

    assign bram_we      = we_reg;
    assign bram_en_a    = we_reg;
    assign bram_addr    = addr_reg;
    assign bram_wr_data = data_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign count        = count_reg;

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snap_capture_ctrl
//
// Randomized bench for snap_capture_ctrl. A behavioural model tracks the
// capture phase and the number of words taken and predicts every output;
// outputs are compared on each falling edge. Directed literal checks pin the
// key timing points (first write latency, trigger alignment, termination,
// re-arm, held arm, asynchronous reset).
// -----------------------------------------------------------------------------
module tb_snap_capture_ctrl;

    localparam int DW    = 128;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            arm = 1'b0;
    logic            use_trig = 1'b0;
    logic            trig = 1'b0;
    logic [DW-1:0]   din = '0;
    logic            din_valid = 1'b0;
    logic            bram_we;
    logic            bram_en_a;
    logic [AW-1:0]   bram_addr;
    logic [DW-1:0]   bram_wr_data;
    logic            busy;
    logic            done;
    logic [AW:0]     count;

    snap_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .use_trig     (use_trig),
        .trig         (trig),
        .din          (din),
        .din_valid    (din_valid),
        .bram_we      (bram_we),
        .bram_en_a    (bram_en_a),
        .bram_addr    (bram_addr),
        .bram_wr_data (bram_wr_data),
        .busy         (busy),
        .done         (done),
        .count        (count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 waiting for start, 2 taking words, 3 buffer full
    int          m_phase = 0;
    int          m_taken = 0;
    int          m_addr  = 0;
    logic [DW-1:0] m_data = '0;
    logic        m_we    = 1'b0;
    logic        m_prev_arm = 1'b0;

    task automatic model_take();
        m_we    = 1'b1;
        m_addr  = m_taken;
        m_data  = din;
        m_taken = m_taken + 1;
        if (m_taken == DEPTH) m_phase = 3;
    endtask

    task automatic model_step();
        logic rise;
        if (!rst_n) begin
            m_phase = 0; m_taken = 0; m_addr = 0; m_data = '0;
            m_we = 1'b0; m_prev_arm = 1'b0;
        end else begin
            rise       = arm && !m_prev_arm;
            m_prev_arm = arm;
            m_we       = 1'b0;
            if (m_phase == 0 || m_phase == 3) begin
                if (rise) begin
                    m_taken = 0;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (!use_trig || trig) begin
                    m_phase = 2;
                    if (din_valid) model_take();
                end
            end else begin
                if (din_valid) model_take();
            end
        end
    endtask

    always @(posedge clk) model_step();

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;
    int wr_total = 0;
    logic [DW-1:0] tb_mem [0:DEPTH-1];

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance to the next falling edge, compare every output against the
    // model (or zero under reset), and log the BRAM write, if any.
    task automatic tick();
        logic m_busy, m_done;
        @(negedge clk);
        if (!rst_n) begin
            check("rst_we", DW'(bram_we), '0);
            check("rst_en", DW'(bram_en_a), '0);
            check("rst_busy", DW'(busy), '0);
            check("rst_done", DW'(done), '0);
            check("rst_count", DW'(count), '0);
        end else begin
            m_busy = (m_phase == 1) || (m_phase == 2);
            m_done = (m_phase == 3);
            check("we", DW'(bram_we), DW'(m_we));
            check("en_a", DW'(bram_en_a), DW'(m_we));
            check("addr", DW'(bram_addr), DW'(m_addr));
            check("wr_data", bram_wr_data, m_data);
            check("busy", DW'(busy), DW'(m_busy));
            check("done", DW'(done), DW'(m_done));
            check("count", DW'(count), DW'(m_taken));
        end
        if (bram_we === 1'b1) begin
            tb_mem[bram_addr] = bram_wr_data;
            wr_total++;
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int wr_base;
        int i;
        int bad;
        int rp;
        logic seen;

        // Reset state
        for (int k = 0; k < 3; k++) tick();
        rst_n = 1'b1;
        din_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            din = rnd_word();
            tick();
        end
        check("idle_no_writes", DW'(wr_total), '0);

        // Free-run capture: din = index, continuous valid
        wr_base = wr_total;
        arm = 1'b1; use_trig = 1'b0; din_valid = 1'b1; din = '0;
        tick();
        din = '0;
        tick();
        check("first_we", DW'(bram_we), DW'(1));
        check("first_addr", DW'(bram_addr), '0);
        check("first_data", bram_wr_data, '0);
        seen = 1'b0;
        for (i = 1; i < 1100; i++) begin
            din = DW'(i);
            tick();
            if (done) begin seen = 1'b1; break; end
        end
        check("free_done_seen", DW'(seen), DW'(1));
        check("free_done_index", DW'(i), DW'(1023));
        check("free_last_we", DW'(bram_we), DW'(1));
        check("free_last_addr", DW'(bram_addr), DW'(1023));
        check("free_count", DW'(count), DW'(1024));
        check("free_busy", DW'(busy), '0);
        check("free_writes", DW'(wr_total - wr_base), DW'(1024));
        bad = 0;
        for (int a = 0; a < DEPTH; a++) if (tb_mem[a] !== DW'(a)) bad++;
        check("free_mem_bad", DW'(bad), '0);

        // Held arm through DONE: no new capture
        wr_base = wr_total;
        for (int k = 0; k < 20; k++) begin
            din = rnd_word();
            trig = 1'(($urandom));
            tick();
        end
        check("held_writes", DW'(wr_total - wr_base), '0);
        check("held_done", DW'(done), DW'(1));
        check("held_count", DW'(count), DW'(1024));

        // Re-arm from DONE, triggered capture
        arm = 1'b0; trig = 1'b0;
        tick();
        arm = 1'b1; use_trig = 1'b1; din_valid = 1'b1;
        tick();
        check("rearm_count", DW'(count), '0);
        check("rearm_done", DW'(done), '0);
        check("rearm_busy", DW'(busy), DW'(1));
        wr_base = wr_total;
        for (int k = 0; k < 5 + int'($urandom_range(0, 10)); k++) begin
            din = rnd_word();
            din_valid = 1'($urandom);
            tick();
        end
        check("pretrig_writes", DW'(wr_total - wr_base), '0);
        trig = 1'b1; din = DW'(8'h55); din_valid = 1'b1;
        tick();
        check("trig_we", DW'(bram_we), DW'(1));
        check("trig_addr", DW'(bram_addr), '0);
        check("trig_data", bram_wr_data, DW'(8'h55));
        rp = 0; seen = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            din = rnd_word();
            din_valid = 1'($urandom);
            trig = 1'($urandom);
            use_trig = 1'($urandom);
            if (rp == 0 && count >= 100) begin arm = 1'b0; rp = 1; end
            else if (rp == 1) begin arm = 1'b1; rp = 2; end
            tick();
            if (rp == 2) begin
                check("rearm_ignored_busy", DW'(busy), DW'(1));
                rp = 3;
            end
            if (done) begin seen = 1'b1; break; end
        end
        check("trig_done_seen", DW'(seen), DW'(1));
        check("trig_count", DW'(count), DW'(1024));
        check("trig_writes", DW'(wr_total - wr_base), DW'(1024));

        // Gapped valid: alternating 1/0 starting in the armed cycle
        trig = 1'b0;
        arm = 1'b0;
        tick();
        arm = 1'b1; use_trig = 1'b0; din_valid = 1'b0;
        tick();
        wr_base = wr_total; seen = 1'b0;
        for (i = 0; i < 2200; i++) begin
            din_valid = (i % 2 == 0);
            din = rnd_word();
            tick();
            if (done) begin seen = 1'b1; break; end
        end
        check("gap_done_seen", DW'(seen), DW'(1));
        check("gap_done_index", DW'(i), DW'(2046));
        check("gap_count", DW'(count), DW'(1024));
        check("gap_writes", DW'(wr_total - wr_base), DW'(1024));

        // Asynchronous reset mid-capture at count = 37
        arm = 1'b0;
        tick();
        arm = 1'b1; use_trig = 1'b0; din_valid = 1'b1;
        tick();
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            din = rnd_word();
            tick();
            if (count == 37) begin seen = 1'b1; break; end
        end
        check("rst_reach37", DW'(seen), DW'(1));
        #2 rst_n = 1'b0;
        arm = 1'b0;
        #1;
        check("async_we", DW'(bram_we), '0);
        check("async_busy", DW'(busy), '0);
        check("async_done", DW'(done), '0);
        check("async_count", DW'(count), '0);
        for (int k = 0; k < 3; k++) tick();
        #2 rst_n = 1'b1;
        wr_base = wr_total;
        for (int k = 0; k < 10; k++) begin
            din = rnd_word();
            tick();
        end
        check("post_rst_writes", DW'(wr_total - wr_base), '0);
        check("post_rst_busy", DW'(busy), '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
